// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: shared state encoding, request slot indices and AXI response codes for the 2:1 AXI-lite arbiter
package axil_arb_pkg;
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_RD_DATA = 3'd4
   } state_e;
   localparam logic [1:0] SLOT_M0W    = 2'd0;
   localparam logic [1:0] SLOT_M0R    = 2'd1;
   localparam logic [1:0] SLOT_M1W    = 2'd2;
   localparam logic [1:0] SLOT_M1R    = 2'd3;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axil_arbiter_2to1_rr_pick4.sv
// rr_pick4: combinational round-robin pick of the first active request slot at or after the pointer
module rr_pick4 (
   input  logic [3:0] i_req,
   input  logic [1:0] i_ptr,
   output logic       o_found,
   output logic [1:0] o_slot
);
   logic [3:0] w_rot;
   logic [1:0] w_off;
   // rotate so the pointer slot lands at bit 0; the offset then wraps back mod 4
   assign w_rot   = 4'({i_req, i_req} >> i_ptr);
   assign w_off   = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
   assign o_found = |i_req;
   assign o_slot  = i_ptr + w_off;
endmodule

// File: rtl/axil_arbiter_2to1.sv
// axil_arbiter_2to1: two-master AXI4-Lite arbiter, one transaction in flight, round-robin over four request slots
module axil_arbiter_2to1
   import axil_arb_pkg::*;
#(
   parameter int C_AXI_ADDR_WIDTH = 5,
   parameter int C_AXI_DATA_WIDTH = 32
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   s0_axi_awaddr,
   input  logic [2:0]                    s0_axi_awprot,
   input  logic                          s0_axi_awvalid,
   output logic                          s0_axi_awready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   s0_axi_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] s0_axi_wstrb,
   input  logic                          s0_axi_wvalid,
   output logic                          s0_axi_wready,
   output logic [1:0]                    s0_axi_bresp,
   output logic                          s0_axi_bvalid,
   input  logic                          s0_axi_bready,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   s0_axi_araddr,
   input  logic [2:0]                    s0_axi_arprot,
   input  logic                          s0_axi_arvalid,
   output logic                          s0_axi_arready,
   output logic [C_AXI_DATA_WIDTH-1:0]   s0_axi_rdata,
   output logic [1:0]                    s0_axi_rresp,
   output logic                          s0_axi_rvalid,
   input  logic                          s0_axi_rready,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   s1_axi_awaddr,
   input  logic [2:0]                    s1_axi_awprot,
   input  logic                          s1_axi_awvalid,
   output logic                          s1_axi_awready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   s1_axi_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] s1_axi_wstrb,
   input  logic                          s1_axi_wvalid,
   output logic                          s1_axi_wready,
   output logic [1:0]                    s1_axi_bresp,
   output logic                          s1_axi_bvalid,
   input  logic                          s1_axi_bready,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   s1_axi_araddr,
   input  logic [2:0]                    s1_axi_arprot,
   input  logic                          s1_axi_arvalid,
   output logic                          s1_axi_arready,
   output logic [C_AXI_DATA_WIDTH-1:0]   s1_axi_rdata,
   output logic [1:0]                    s1_axi_rresp,
   output logic                          s1_axi_rvalid,
   input  logic                          s1_axi_rready,
   output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                    m_axi_awprot,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                    m_axi_arprot,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   output logic [1:0]                    grant,
   output logic                          busy
);
   state_e     r_state, w_state_nxt;
   logic       r_owner, w_owner_nxt;
   logic [1:0] r_ptr, w_ptr_nxt, r_grant, w_grant_nxt, w_slot;
   logic [3:0] w_req;
   logic       w_found, w_wa, w_wb, w_ra, w_rb, w_aw_hs, w_b_hs, w_ar_hs, w_r_hs;

   // a write only requests once AW and W are both offered, since the slave takes them together
   assign w_req[SLOT_M0W] = s0_axi_awvalid & s0_axi_wvalid;
   assign w_req[SLOT_M0R] = s0_axi_arvalid;
   assign w_req[SLOT_M1W] = s1_axi_awvalid & s1_axi_wvalid;
   assign w_req[SLOT_M1R] = s1_axi_arvalid;

   rr_pick4 u_pick (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_slot  (w_slot)
   );

   assign w_wa = r_state == ST_WR_ADDR;
   assign w_wb = w_wa | (r_state == ST_WR_RESP);
   assign w_ra = r_state == ST_RD_ADDR;
   assign w_rb = w_ra | (r_state == ST_RD_DATA);

   assign m_axi_awaddr  = r_owner ? s1_axi_awaddr : s0_axi_awaddr;
   assign m_axi_awprot  = r_owner ? s1_axi_awprot : s0_axi_awprot;
   assign m_axi_wdata   = r_owner ? s1_axi_wdata  : s0_axi_wdata;
   assign m_axi_wstrb   = r_owner ? s1_axi_wstrb  : s0_axi_wstrb;
   assign m_axi_araddr  = r_owner ? s1_axi_araddr : s0_axi_araddr;
   assign m_axi_arprot  = r_owner ? s1_axi_arprot : s0_axi_arprot;
   assign m_axi_awvalid = w_wa & (r_owner ? s1_axi_awvalid : s0_axi_awvalid);
   assign m_axi_wvalid  = w_wa & (r_owner ? s1_axi_wvalid  : s0_axi_wvalid);
   assign m_axi_bready  = w_wb & (r_owner ? s1_axi_bready  : s0_axi_bready);
   assign m_axi_arvalid = w_ra & (r_owner ? s1_axi_arvalid : s0_axi_arvalid);
   assign m_axi_rready  = w_rb & (r_owner ? s1_axi_rready  : s0_axi_rready);

   assign s0_axi_awready = w_wa & ~r_owner & m_axi_awready;
   assign s0_axi_wready  = w_wa & ~r_owner & m_axi_wready;
   assign s0_axi_bvalid  = w_wb & ~r_owner & m_axi_bvalid;
   assign s0_axi_arready = w_ra & ~r_owner & m_axi_arready;
   assign s0_axi_rvalid  = w_rb & ~r_owner & m_axi_rvalid;
   assign s1_axi_awready = w_wa &  r_owner & m_axi_awready;
   assign s1_axi_wready  = w_wa &  r_owner & m_axi_wready;
   assign s1_axi_bvalid  = w_wb &  r_owner & m_axi_bvalid;
   assign s1_axi_arready = w_ra &  r_owner & m_axi_arready;
   assign s1_axi_rvalid  = w_rb &  r_owner & m_axi_rvalid;
   assign s0_axi_bresp   = m_axi_bresp;
   assign s1_axi_bresp   = m_axi_bresp;
   assign s0_axi_rresp   = m_axi_rresp;
   assign s1_axi_rresp   = m_axi_rresp;
   assign s0_axi_rdata   = m_axi_rdata;
   assign s1_axi_rdata   = m_axi_rdata;

   assign w_aw_hs = m_axi_awvalid & m_axi_awready & m_axi_wvalid & m_axi_wready;
   assign w_b_hs  = m_axi_bvalid & m_axi_bready;
   assign w_ar_hs = m_axi_arvalid & m_axi_arready;
   assign w_r_hs  = m_axi_rvalid & m_axi_rready;

   assign grant = r_grant;
   assign busy  = r_state != ST_IDLE;

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_grant_nxt = r_grant;
      case (r_state)
         ST_IDLE: if (w_found) begin
            w_state_nxt = w_slot[0] ? ST_RD_ADDR : ST_WR_ADDR;
            w_owner_nxt = w_slot[1];
            w_ptr_nxt   = w_slot + 2'd1;
            w_grant_nxt = w_slot[1] ? 2'b10 : 2'b01;
         end
         ST_WR_ADDR: if (w_aw_hs) w_state_nxt = w_b_hs ? ST_IDLE : ST_WR_RESP;
         ST_WR_RESP: if (w_b_hs) w_state_nxt = ST_IDLE;
         ST_RD_ADDR: if (w_ar_hs) w_state_nxt = w_r_hs ? ST_IDLE : ST_RD_DATA;
         ST_RD_DATA: if (w_r_hs) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
      if (w_state_nxt == ST_IDLE) w_grant_nxt = 2'b00;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= ST_IDLE;
         r_owner <= 1'b0;
         r_ptr   <= 2'd0;
         r_grant <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_grant <= w_grant_nxt;
      end
   end
endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// tb_axil_arbiter_2to1: directed and randomized checks of the 2:1 AXI-lite arbiter against a transaction-level model
module tb_axil_arbiter_2to1;
   logic        aclk = 1'b0;
   logic        areset;
   logic [4:0]  a_waddr [2], a_raddr [2];
   logic [2:0]  a_wprot [2], a_rprot [2];
   logic [31:0] a_wdata [2];
   logic [3:0]  a_strb  [2];
   logic        a_awv [2], a_wv [2], a_arv [2], a_bready [2], a_rready [2];
   logic        s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid;
   logic        s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid;
   logic [1:0]  s0_bresp, s0_rresp, s1_bresp, s1_rresp;
   logic [31:0] s0_rdata, s1_rdata;
   logic [4:0]  m_awaddr, m_araddr;
   logic [2:0]  m_awprot, m_arprot;
   logic [31:0] m_wdata, m_rdata;
   logic [3:0]  m_wstrb;
   logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
   logic [1:0]  m_bresp, m_rresp, grant;
   logic        busy;
   logic [4:0]  up0, up1;
   logic [31:0] slv_mem [8] = '{default: 32'h0};
   logic [31:0] ref_mem [8] = '{default: 32'h0};
   int          n_tests = 0, n_fail = 0, m_ptr = 0;

   always #5 aclk = ~aclk;

   axil_arbiter_2to1 dut (
      .aclk(aclk), .areset(areset),
      .s0_axi_awaddr(a_waddr[0]), .s0_axi_awprot(a_wprot[0]), .s0_axi_awvalid(a_awv[0]), .s0_axi_awready(s0_awready),
      .s0_axi_wdata(a_wdata[0]), .s0_axi_wstrb(a_strb[0]), .s0_axi_wvalid(a_wv[0]), .s0_axi_wready(s0_wready),
      .s0_axi_bresp(s0_bresp), .s0_axi_bvalid(s0_bvalid), .s0_axi_bready(a_bready[0]),
      .s0_axi_araddr(a_raddr[0]), .s0_axi_arprot(a_rprot[0]), .s0_axi_arvalid(a_arv[0]), .s0_axi_arready(s0_arready),
      .s0_axi_rdata(s0_rdata), .s0_axi_rresp(s0_rresp), .s0_axi_rvalid(s0_rvalid), .s0_axi_rready(a_rready[0]),
      .s1_axi_awaddr(a_waddr[1]), .s1_axi_awprot(a_wprot[1]), .s1_axi_awvalid(a_awv[1]), .s1_axi_awready(s1_awready),
      .s1_axi_wdata(a_wdata[1]), .s1_axi_wstrb(a_strb[1]), .s1_axi_wvalid(a_wv[1]), .s1_axi_wready(s1_wready),
      .s1_axi_bresp(s1_bresp), .s1_axi_bvalid(s1_bvalid), .s1_axi_bready(a_bready[1]),
      .s1_axi_araddr(a_raddr[1]), .s1_axi_arprot(a_rprot[1]), .s1_axi_arvalid(a_arv[1]), .s1_axi_arready(s1_arready),
      .s1_axi_rdata(s1_rdata), .s1_axi_rresp(s1_rresp), .s1_axi_rvalid(s1_rvalid), .s1_axi_rready(a_rready[1]),
      .m_axi_awaddr(m_awaddr), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid), .m_axi_awready(1'b1),
      .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(1'b1),
      .m_axi_bresp(m_bresp), .m_axi_bvalid(1'b1), .m_axi_bready(m_bready),
      .m_axi_araddr(m_araddr), .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(1'b1),
      .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(1'b1), .m_axi_rready(m_rready),
      .grant(grant), .busy(busy)
   );

   // zero-wait slave: 8 words, addresses 0x18 and up answer SLVERR
   assign m_bresp = (m_awaddr >= 5'h18) ? 2'b10 : 2'b00;
   assign m_rresp = (m_araddr >= 5'h18) ? 2'b10 : 2'b00;
   assign m_rdata = slv_mem[m_araddr[4:2]];
   always @(posedge aclk)
      if (m_awvalid && m_wvalid && m_awaddr < 5'h18)
         for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) slv_mem[m_awaddr[4:2]][8*b +: 8] <= m_wdata[8*b +: 8];

   assign up0 = {s0_awready, s0_wready, s0_arready, s0_bvalid, s0_rvalid};
   assign up1 = {s1_awready, s1_wready, s1_arready, s1_bvalid, s1_rvalid};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #2;
   endtask

   function automatic int pick(input logic [3:0] req, input int ptr);
      int r = -1;
      for (int i = 0; i < 4; i++)
         if (r < 0 && req[(ptr + i) % 4]) r = (ptr + i) % 4;
      return r;
   endfunction

   function automatic logic [1:0] resp(input logic [4:0] a);
      return (a >= 5'h18) ? 2'b10 : 2'b00;
   endfunction

   function automatic void ref_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      if (a < 5'h18)
         for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[4:2]][8*b +: 8] = d[8*b +: 8];
   endfunction

   task automatic drive(input logic [3:0] req);
      a_awv[0] = req[0]; a_wv[0] = req[0]; a_arv[0] = req[1];
      a_awv[1] = req[2]; a_wv[1] = req[2]; a_arv[1] = req[3];
   endtask

   task automatic randomize_fields();
      for (int m = 0; m < 2; m++) begin
         a_waddr[m] = 5'($urandom_range(0, 7) * 4);
         a_raddr[m] = 5'($urandom_range(0, 7) * 4);
         a_wdata[m] = $urandom;
         a_strb[m]  = 4'($urandom);
         a_wprot[m] = 3'($urandom);
         a_rprot[m] = 3'($urandom);
      end
   endtask

   // one arbitration: request set offered in IDLE, check the forwarded transfer, then the return to IDLE
   task automatic round(input logic [3:0] req);
      int slot, own;
      drive(req);
      step();
      slot = pick(req, m_ptr);
      if (slot < 0) begin
         chk("idle_grant", 64'(grant), 64'd0);
         chk("idle_busy", 64'(busy), 64'd0);
      end else begin
         own   = slot / 2;
         m_ptr = (slot + 1) % 4;
         chk("grant", 64'(grant), (own == 1) ? 64'd2 : 64'd1);
         chk("busy", 64'(busy), 64'd1);
         chk("other_up", 64'((own == 1) ? up0 : up1), 64'd0);
         if (slot % 2 == 0) begin
            chk("own_up_wr", 64'((own == 1) ? up1 : up0), 64'b11010);
            chk("m_aw", 64'({m_awvalid, m_wvalid, m_arvalid, m_awaddr, m_awprot, m_wstrb}),
                64'({3'b110, a_waddr[own], a_wprot[own], a_strb[own]}));
            chk("m_wdata", 64'(m_wdata), 64'(a_wdata[own]));
            chk("bresp", 64'((own == 1) ? s1_bresp : s0_bresp), 64'(resp(a_waddr[own])));
            ref_write(a_waddr[own], a_wdata[own], a_strb[own]);
         end else begin
            chk("own_up_rd", 64'((own == 1) ? up1 : up0), 64'b00101);
            chk("m_ar", 64'({m_awvalid, m_wvalid, m_arvalid, m_araddr, m_arprot}),
                64'({3'b001, a_raddr[own], a_rprot[own]}));
            chk("rdata", 64'((own == 1) ? s1_rdata : s0_rdata), 64'(ref_mem[a_raddr[own][4:2]]));
            chk("rresp", 64'((own == 1) ? s1_rresp : s0_rresp), 64'(resp(a_raddr[own])));
         end
         step();
         chk("done", 64'({busy, grant}), 64'd0);
      end
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         a_waddr[m] = '0; a_raddr[m] = '0; a_wprot[m] = '0; a_rprot[m] = '0;
         a_wdata[m] = '0; a_strb[m] = '0; a_bready[m] = 1'b1; a_rready[m] = 1'b1;
      end
      // reset with every request raised: IDLE must keep all handshakes closed
      areset = 1'b1;
      drive(4'hF);
      step();
      step();
      chk("rst_state", 64'({busy, grant, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 64'd0);
      chk("rst_up", 64'({up0, up1}), 64'd0);
      drive(4'h0);
      areset = 1'b0;
      step();

      // M0 write and M1 read together, M0 holds bready low for three cycles
      a_waddr[0] = 5'h04; a_wdata[0] = 32'h0000_5A00; a_strb[0] = 4'h2; a_bready[0] = 1'b0;
      a_raddr[1] = 5'h04;
      drive(4'b1001);
      step();
      chk("t4_grant", 64'(grant), 64'd1);
      chk("t4_m_aw", 64'({m_awvalid, m_awaddr, m_wdata}), 64'({1'b1, 5'h04, 32'h0000_5A00}));
      ref_write(5'h04, 32'h0000_5A00, 4'h2);
      m_ptr = 1;
      step();
      a_awv[0] = 1'b0; a_wv[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4_hold", 64'({busy, grant, m_awvalid, m_arvalid}), 64'b1_01_0_0);
         chk("t4_b", 64'({s0_bvalid, s0_bresp, up1}), 64'({1'b1, 2'b00, 5'b0}));
         step();
      end
      a_bready[0] = 1'b1;
      step();
      chk("t4_idle", 64'({busy, grant}), 64'd0);
      step();
      chk("t2_m1_grant", 64'(grant), 64'd2);
      chk("t2_m1_rdata", 64'({s1_rvalid, s1_rresp, s1_rdata}), 64'({1'b1, 2'b00, ref_mem[1]}));
      m_ptr = 0;
      step();
      a_arv[1] = 1'b0;

      // both masters requesting everything: strict rotation M0W, M0R, M1W, M1R
      for (int i = 0; i < 8; i++) begin
         randomize_fields();
         round(4'hF);
      end

      // single M0 write of 0xA5 to 0x04, byte 0
      a_waddr[0] = 5'h04; a_wdata[0] = 32'h0000_00A5; a_strb[0] = 4'h1; a_wprot[0] = 3'h0;
      round(4'b0001);

      // M1 read of an unmapped address gets SLVERR
      a_raddr[1] = 5'h1E;
      round(4'b1000);

      // reset while M0 waits in the read data phase, then two writes compete from slot 0
      a_raddr[0] = 5'h08; a_rready[0] = 1'b0;
      drive(4'b0010);
      step();
      chk("t6_grant", 64'(grant), 64'd1);
      step();
      drive(4'b0000);
      chk("t6_rdata_wait", 64'({busy, s0_rvalid, m_rready}), 64'b110);
      areset = 1'b1;
      drive(4'b0101);
      step();
      chk("t6_rst", 64'({busy, grant, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, up0, up1}), 64'd0);
      areset = 1'b0; a_rready[0] = 1'b1;
      step();
      chk("t6_after_rst", 64'(grant), 64'd1);
      ref_write(a_waddr[0], a_wdata[0], a_strb[0]);
      m_ptr = 1;
      step();
      drive(4'b0000);
      step();

      for (int i = 0; i < 40; i++) begin
         randomize_fields();
         round(4'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
